stopwatch_display: RTL and testbench
====================================

# stopwatch_display

- Consumes the `minutes`/`seconds` binary counts (0–59) produced by the stopwatch core.
- Converts them to BCD with a sequential repeated-subtraction engine.
- Drives a 4-digit, common-anode, time-multiplexed 7-segment display showing MM.SS.
- In adjust mode, blinks the field currently being adjusted.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit (≥2).
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period (≥2).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `minutes`  in  8  binary minutes; sampled only on an accepted `valid`.
- `seconds`  in  8  binary seconds; sampled only on an accepted `valid`.
- `valid`  in  1  one-cycle strobe: new `minutes`/`seconds` available.
- `busy`  out  1  high while a conversion is in progress; `valid` is dropped while high.
- `adj`  in  1  1 = adjust mode, blink the selected field.
- `sel`  in  1  0 = minutes field, 1 = seconds field.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `dp`  out  1  decimal point, active-low, registered.
- `an`  out  4  digit anodes, active-low one-hot, registered.

## Operation
- **Snapshot.** On `valid`=1 with `busy`=0, latch `minutes` and `seconds` into working registers and go to CONV_MIN.
- **Converter FSM.** States IDLE → CONV_MIN → CONV_SEC → IDLE.
  - In each CONV state, once per cycle: if remainder ≥ 10, subtract 10 and increment tens; else ones = remainder and advance to the next state.
  - `busy` = (state ≠ IDLE).
- **Out-of-range input.** A field ≥ 60 is not converted. It is flagged invalid and takes 1 cycle in its CONV state; its two digits display dash (g only lit, `seg`=7'b0111111).
- **Atomic commit.** Display digit registers (min_t, min_o, sec_t, sec_o, invalid flags) update together on the CONV_SEC → IDLE transition. A partially converted value is never displayed.
- **Scan.**
  - Scan counter runs 0..SCAN_DIV-1; at terminal count, digit index advances 0→1→2→3→0.
  - Digit mapping: 0 = sec_o (an=1110), 1 = sec_t (1101), 2 = min_o (1011), 3 = min_t (0111).
  - `dp`=0 only while index 2 is lit (MM.SS separator); otherwise 1.
- **Decode.** Standard hex 0–9 active-low (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
- **Blink.**
  - Blink counter runs 0..BLINK_DIV-1 and toggles the phase at terminal count.
  - While `adj`=0, counter and phase are held at 0 (visible), so entering adjust always starts visible.
  - While `adj`=1 and phase=1, digits of the selected field (`sel`=0: indices 3,2; `sel`=1: indices 1,0) drive `seg`=7'h7F. `dp` is unaffected.

## Timing
- **Reset (synchronous).** On the first edge with `rst`=1:
  - state=IDLE, `busy`=0, all digit regs 0, invalid flags 0.
  - scan counter and index 0, blink counter and phase 0.
  - `an`=1111, `seg`=7'h7F, `dp`=1.
- **First lit digit.** On the first edge after `rst` deasserts, `an`=1110, `seg`=1000000 (display 00.00).
- **Mid-operation reset.** `rst` during a conversion aborts it and discards the pending value.
- **Conversion latency.** With `valid` accepted at edge N, `busy`=1 from N+1. Commit occurs at edge N + (⌊m/10⌋+1) + (⌊s/10⌋+1), where a term is 1 for an out-of-range field.
  - Worst case 59:59 = 12 cycles.
  - `busy` falls on the commit edge; `valid` in that same cycle is accepted.
- **Output register delay.** `seg`/`an`/`dp` are registered: a committed digit, index change, or blink-phase change appears 1 cycle later.
- **Simultaneous events.** `valid` asserted while `busy`=1 is ignored; there is no queue. Changes in `adj` or `sel` take effect on the next output register update.

## Test plan
- **Reset and idle scan** (SCAN_DIV=4): apply reset, then idle → `an` cycles 1110, 1101, 1011, 0111, 4 clocks each; `seg`=1000000 throughout; `dp`=0 only with `an`=1011.
- **Latency and digits:** valid with minutes=59, seconds=59 → `busy` high exactly 12 cycles; then digits read 9,5,9,5 for indices 0–3 (`seg` 0010000 / 0010010).
- **Dropped valid:** valid with 12:34, then a second valid (00:07) 2 cycles later → second dropped; display shows 12.34.
- **Out-of-range:** valid with minutes=75, seconds=3 → minutes digits show 0111111, seconds digits show 0,3; `busy` lasts 2 cycles.
- **Blink** (BLINK_DIV=8): `adj`=1, `sel`=1 → seconds digits blank (7'h7F) for alternating 8-cycle windows; minutes digits are never blanked. `adj`=0 → blanking stops within 1 cycle.
- **Reset mid-conversion:** assert `rst` 3 cycles after valid(45:30) → `busy`=0; display 00.00; no commit afterwards.

Source files
------------

// File: rtl/stopwatch_display.sv
// Stopwatch display driver: converts binary minutes/seconds to BCD with a
// repeated-subtraction engine and scans them onto a 4-digit common-anode
// 7-segment display as MM.SS, blinking the selected field in adjust mode.
module stopwatch_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] minutes,
    input  logic [7:0] seconds,
    input  logic       valid,
    output logic       busy,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV_MIN,
        CONV_SEC
    } state_t;

    state_t state_q, state_d;

    logic [7:0] rem_q, rem_d;
    logic [7:0] secHold_q, secHold_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] pendMinT_q, pendMinT_d;
    logic [3:0] pendMinO_q, pendMinO_d;
    logic       pendMinInv_q, pendMinInv_d;

    logic [3:0] minT_q, minT_d;
    logic [3:0] minO_q, minO_d;
    logic [3:0] secT_q, secT_d;
    logic [3:0] secO_q, secO_d;
    logic       minInv_q, minInv_d;
    logic       secInv_q, secInv_d;

    logic [SCAN_W-1:0]  scanCnt_q;
    logic [1:0]         idx_q;
    logic [BLINK_W-1:0] blinkCnt_q;
    logic               phase_q;

    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [3:0] an_q, an_d;

    logic [3:0] curDigit;
    logic       curInv;
    logic       curIsSec;

    // Active-low 7-segment pattern {g,f,e,d,c,b,a} for a BCD digit.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'h7F;
        endcase
    endfunction

    // Converter next state: snapshot, subtract-by-ten per field, atomic commit.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        secHold_d    = secHold_q;
        tens_d       = tens_q;
        pendMinT_d   = pendMinT_q;
        pendMinO_d   = pendMinO_q;
        pendMinInv_d = pendMinInv_q;
        minT_d       = minT_q;
        minO_d       = minO_q;
        secT_d       = secT_q;
        secO_d       = secO_q;
        minInv_d     = minInv_q;
        secInv_d     = secInv_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    rem_d     = minutes;
                    secHold_d = seconds;
                    tens_d    = 4'd0;
                    state_d   = CONV_MIN;
                end
            end
            CONV_MIN: begin
                if (rem_q >= 8'd60) begin
                    pendMinInv_d = 1'b1;
                    pendMinT_d   = 4'd0;
                    pendMinO_d   = 4'd0;
                    rem_d        = secHold_q;
                    tens_d       = 4'd0;
                    state_d      = CONV_SEC;
                end else if (rem_q >= 8'd10) begin
                    rem_d  = rem_q - 8'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    pendMinInv_d = 1'b0;
                    pendMinT_d   = tens_q;
                    pendMinO_d   = rem_q[3:0];
                    rem_d        = secHold_q;
                    tens_d       = 4'd0;
                    state_d      = CONV_SEC;
                end
            end
            CONV_SEC: begin
                if (rem_q >= 8'd60) begin
                    minT_d   = pendMinT_q;
                    minO_d   = pendMinO_q;
                    minInv_d = pendMinInv_q;
                    secT_d   = 4'd0;
                    secO_d   = 4'd0;
                    secInv_d = 1'b1;
                    state_d  = IDLE;
                end else if (rem_q >= 8'd10) begin
                    rem_d  = rem_q - 8'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    minT_d   = pendMinT_q;
                    minO_d   = pendMinO_q;
                    minInv_d = pendMinInv_q;
                    secT_d   = tens_q;
                    secO_d   = rem_q[3:0];
                    secInv_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Converter and committed-digit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= 8'd0;
            secHold_q    <= 8'd0;
            tens_q       <= 4'd0;
            pendMinT_q   <= 4'd0;
            pendMinO_q   <= 4'd0;
            pendMinInv_q <= 1'b0;
            minT_q       <= 4'd0;
            minO_q       <= 4'd0;
            secT_q       <= 4'd0;
            secO_q       <= 4'd0;
            minInv_q     <= 1'b0;
            secInv_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            secHold_q    <= secHold_d;
            tens_q       <= tens_d;
            pendMinT_q   <= pendMinT_d;
            pendMinO_q   <= pendMinO_d;
            pendMinInv_q <= pendMinInv_d;
            minT_q       <= minT_d;
            minO_q       <= minO_d;
            secT_q       <= secT_d;
            secO_q       <= secO_d;
            minInv_q     <= minInv_d;
            secInv_q     <= secInv_d;
        end
    end

    // Digit scan timer: each digit stays lit for SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            scanCnt_q <= '0;
            idx_q     <= 2'd0;
        end else if (scanCnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scanCnt_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            scanCnt_q <= scanCnt_q + 1'b1;
        end
    end

    // Blink timer, parked at visible phase whenever adjust mode is off.
    always_ff @(posedge clk) begin
        if (rst || !adj) begin
            blinkCnt_q <= '0;
            phase_q    <= 1'b0;
        end else if (blinkCnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blinkCnt_q <= '0;
            phase_q    <= ~phase_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + 1'b1;
        end
    end

    // Select the lit digit, decode it and apply dash/blank overrides.
    always_comb begin
        an_d     = 4'b1110;
        curDigit = secO_q;
        curInv   = secInv_q;
        curIsSec = 1'b1;
        case (idx_q)
            2'd0: begin an_d = 4'b1110; curDigit = secO_q; curInv = secInv_q; curIsSec = 1'b1; end
            2'd1: begin an_d = 4'b1101; curDigit = secT_q; curInv = secInv_q; curIsSec = 1'b1; end
            2'd2: begin an_d = 4'b1011; curDigit = minO_q; curInv = minInv_q; curIsSec = 1'b0; end
            default: begin an_d = 4'b0111; curDigit = minT_q; curInv = minInv_q; curIsSec = 1'b0; end
        endcase
        seg_d = curInv ? 7'b0111111 : decode(curDigit);
        if (adj && phase_q && (curIsSec == sel)) begin
            seg_d = 7'h7F;
        end
        dp_d = (idx_q == 2'd2) ? 1'b0 : 1'b1;
    end

    // Registered display outputs, all dark during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= 4'b1111;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed self-checking bench for stopwatch_display with short scan/blink periods.
module tb_stopwatch_display;

    localparam int SCAN  = 4;
    localparam int BLINK = 8;

    localparam logic [6:0] SEG0    = 7'b1000000;
    localparam logic [6:0] SEG1    = 7'b1111001;
    localparam logic [6:0] SEG2    = 7'b0100100;
    localparam logic [6:0] SEG3    = 7'b0110000;
    localparam logic [6:0] SEG4    = 7'b0011001;
    localparam logic [6:0] SEG5    = 7'b0010010;
    localparam logic [6:0] SEG9    = 7'b0010000;
    localparam logic [6:0] SEGDASH = 7'b0111111;
    localparam logic [6:0] SEGOFF  = 7'h7F;

    logic       clk;
    logic       rst;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       valid;
    logic       busy;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int testsRun;
    int testsFailed;

    logic [3:0] anPat [4];

    stopwatch_display #(
        .SCAN_DIV (SCAN),
        .BLINK_DIV(BLINK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .minutes(minutes),
        .seconds(seconds),
        .valid  (valid),
        .busy   (busy),
        .adj    (adj),
        .sel    (sel),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0b, expected %0b", tag, observed, expected);
        end
    endtask

    // Present one valid strobe with the given minutes/seconds for one cycle.
    task automatic applyStimulus(input logic [7:0] m, input logic [7:0] s);
        minutes = m;
        seconds = s;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
    endtask

    // Count cycles that busy stays high, bounded.
    task automatic measureBusy(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Wait for each anode in turn and check its segments and decimal point.
    task automatic checkDisplay(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                                input logic [6:0] d2, input logic [6:0] d3);
        logic [6:0] expSeg [4];
        int guard;
        expSeg[0] = d0;
        expSeg[1] = d1;
        expSeg[2] = d2;
        expSeg[3] = d3;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (an !== anPat[i] && guard < 4 * SCAN + 8) begin
                @(negedge clk);
                guard++;
            end
            checkOutput($sformatf("%s_an%0d", tag, i), 32'(an), 32'(anPat[i]));
            checkOutput($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(expSeg[i]));
            checkOutput($sformatf("%s_dp%0d", tag, i), 32'(dp), (i == 2) ? 32'd0 : 32'd1);
        end
    endtask

    // Directed test sequence.
    initial begin
        int cycles;
        int highCount;
        logic blankExp;
        logic [6:0] segExp;

        testsRun    = 0;
        testsFailed = 0;
        anPat[0] = 4'b1110;
        anPat[1] = 4'b1101;
        anPat[2] = 4'b1011;
        anPat[3] = 4'b0111;

        rst     = 1'b1;
        minutes = 8'd0;
        seconds = 8'd0;
        valid   = 1'b0;
        adj     = 1'b0;
        sel     = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_an", 32'(an), 32'b1111);
        checkOutput("rst_seg", 32'(seg), 32'(SEGOFF));
        checkOutput("rst_dp", 32'(dp), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Idle scan: four clocks per digit, display 00.00
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checkOutput($sformatf("scan_an_k%0d", k), 32'(an), 32'(anPat[((k - 1) / 4) % 4]));
            checkOutput($sformatf("scan_seg_k%0d", k), 32'(seg), 32'(SEG0));
            checkOutput($sformatf("scan_dp_k%0d", k), 32'(dp), ((((k - 1) / 4) % 4) == 2) ? 32'd0 : 32'd1);
        end

        // Worst-case latency 59:59
        applyStimulus(8'd59, 8'd59);
        checkOutput("lat_busy_rise", 32'(busy), 32'd1);
        measureBusy(cycles);
        checkOutput("lat_busy_cycles", 32'(cycles), 32'd12);
        @(negedge clk);
        checkDisplay("lat", SEG9, SEG5, SEG9, SEG5);

        // Second valid while busy is dropped
        applyStimulus(8'd12, 8'd34);
        @(negedge clk);
        applyStimulus(8'd0, 8'd7);
        measureBusy(cycles);
        checkOutput("drop_busy_cycles", 32'(cycles), 32'd4);
        highCount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy === 1'b1) highCount++;
        end
        checkOutput("drop_no_restart", 32'(highCount), 32'd0);
        checkDisplay("drop", SEG4, SEG3, SEG2, SEG1);

        // Out-of-range minutes
        applyStimulus(8'd75, 8'd3);
        measureBusy(cycles);
        checkOutput("oor_busy_cycles", 32'(cycles), 32'd2);
        @(negedge clk);
        checkDisplay("oor", SEG3, SEG0, SEGDASH, SEGDASH);

        // Blink seconds field in adjust mode
        adj = 1'b1;
        sel = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            blankExp = (((k - 1) / BLINK) % 2) == 1;
            case (an)
                4'b1110: segExp = blankExp ? SEGOFF : SEG3;
                4'b1101: segExp = blankExp ? SEGOFF : SEG0;
                default: segExp = SEGDASH;
            endcase
            checkOutput($sformatf("blink_seg_k%0d", k), 32'(seg), 32'(segExp));
        end
        adj = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: segExp = SEG3;
                4'b1101: segExp = SEG0;
                default: segExp = SEGDASH;
            endcase
            checkOutput($sformatf("unblink_seg_k%0d", k), 32'(seg), 32'(segExp));
        end

        // Reset in the middle of a conversion
        applyStimulus(8'd45, 8'd30);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_an", 32'(an), 32'b1111);
        rst = 1'b0;
        highCount = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (busy === 1'b1) highCount++;
        end
        checkOutput("midrst_no_busy", 32'(highCount), 32'd0);
        checkDisplay("midrst", SEG0, SEG0, SEG0, SEG0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
